msg_schedule_fetch: RTL
=======================

# msg_schedule_fetch

Initiator side of the message-word interface. Pulls each 512-bit block from the message controller as 16 big-endian 32-bit words, expands them into the 64-entry SHA-256 message schedule (W0..W63) with a 16-word sliding window, and streams one W_t per cycle to the compression rounds. It owns block sequencing (`current_block`, `busy`) toward the controller and the `w_*` stream toward the round logic.

## Interface
- Parameters: none. SHA-256 constants are fixed and live in the package.
- `clk`  in  1  clock; the single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `msg_ready`  in  1  controller has all blocks padded and stored (its `done`).
- `num_blocks`  in  4  index of the last block (block count − 1).
- `word_data`  in  32  requested word, big-endian.
- `word_valid`  in  1  `word_data` is valid this cycle.
- `req_word`  out  1  word request.
- `word_address`  out  8  word index: `{current_block, word_idx[3:0]}`.
- `current_block`  out  4  block being scheduled.
- `busy`  out  1  a block is being fetched or expanded.
- `w_out`  out  32  schedule word W_t.
- `w_valid`  out  1  `w_out` is valid.
- `w_round`  out  6  t for `w_out`.
- `w_ready`  in  1  round logic accepts `w_out`.
- `block_done`  out  1  one-cycle pulse after W63 of a block is accepted.
- `all_done`  out  1  one-cycle pulse after the last block completes.

## Operation
- The output register advances when `adv = !w_valid || w_ready`.
- **States and transitions:**
  - IDLE: → FETCH when `msg_ready`. `current_block` = 0.
  - FETCH: `req_word = adv`.
    - On `req_word && word_valid`, the word is loaded into the window and the output register; `w_round` = word_idx.
    - `word_idx` increments.
    - → EXPAND after word 15 is captured.
    - If `word_valid` is low, nothing advances and the request repeats.
  - EXPAND: on each `adv`, t = 16..63. `W_t = σ1(W[t−2]) + W[t−7] + σ0(W[t−15]) + W[t−16]`, mod 2^32. The window shifts by one. → BLOCK_END when W63 is accepted.
  - BLOCK_END: pulse `block_done`.
    - If `current_block < num_blocks`: increment `current_block` and go to WAIT.
    - Otherwise: pulse `all_done` and go to IDLE.
  - WAIT: `busy` = 0 for one cycle, letting the controller re-enter its provide phase. → FETCH when `msg_ready`.
- `busy` = 1 in FETCH, EXPAND and BLOCK_END.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3. σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Boundary rules:
  - `w_ready` low holds `w_out`, `w_round`, the window and `req_word` low.
  - A `word_valid` with no `req_word` is ignored.
  - `num_blocks` = 0 means a single block.
  - `num_blocks` = 15 wraps `word_address` to 0xF0..0xFF. No overflow past that.
  - `msg_ready` dropping during FETCH does not abort. The block completes.
  - `rst_n` low mid-block clears everything immediately. Partial output is discarded.
- **Reset values:** state IDLE; `req_word`, `busy`, `w_valid`, `block_done`, `all_done` = 0; `word_address`, `current_block`, `w_out`, `w_round` = 0.

## Timing
- `req_word` and `word_address` are combinational from state and `adv`.
- `word_data` is sampled in the same cycle as `req_word && word_valid`. `w_out` is registered and valid the next cycle.
- Steady state with `w_ready` = 1 and `word_valid` = 1: one W per cycle.
  - W0 appears 2 cycles after IDLE sees `msg_ready`.
  - 64 W cycles, plus BLOCK_END, plus WAIT: 66 cycles per non-final block.
- `block_done` and `all_done` assert in the cycle after W63's handshake.

## Structure
- Package `sha256_pkg`:
  - state enum `sched_state_t`;
  - functions `sig0` and `sig1`;
  - constants `WORDS_PER_BLOCK` = 16 and `ROUNDS` = 64.
- Sub-module `msg_window`: 16×32 shift register with a `shift_en` input and taps at t−2, t−7, t−15 and t−16. It contains the adder tree that computes the next W. The top-level FSM instantiates it once.

## Test plan
- **"abc" single block** (words 0x61626380, then 0 ×14, then 0x00000018; `num_blocks` = 0): W0 = 0x61626380, W15 = 0x00000018, W16 = 0x61626380, W17 = 0x000F0000. `block_done` and `all_done` pulse once. `word_address` runs 0x00..0x0F.
- **Two blocks** (`num_blocks` = 1): addresses 0x00..0x0F, then 0x10..0x1F. `busy` is low for exactly one WAIT cycle between blocks. `all_done` fires only after block 1.
- **Backpressure:** `w_ready` low for 5 cycles at t = 20. `w_out` and `w_round` = 20 hold. The stream resumes with t = 21 and W matches the golden model.
- **Word stall:** `word_valid` low for 3 cycles at word_idx 7. `req_word` stays high and the address stays at 0x07. No W is emitted during the stall.
- **Reset mid-EXPAND** (t = 40): all outputs return to reset values. A subsequent `msg_ready` restarts from block 0, address 0x00.
- **Random 1–4 block messages:** all 64·n W values match the reference SHA-256 schedule model.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule types and helpers.
// Holds the FSM state encoding and the small sigma functions used by the expander.
package sha256_pkg;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int ROUNDS          = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXPAND,
    S_BLOCK_END,
    S_WAIT
  } sched_state_t;

  // sigma0 = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1 = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

endpackage

// File: rtl/msg_schedule_fetch_if.sv
// Message-word fetch bus toward the controller plus the W_t stream toward the rounds.
// The master side is the schedule fetcher.
interface msg_schedule_fetch_if;
  logic        msg_ready;
  logic [3:0]  num_blocks;
  logic [31:0] word_data;
  logic        word_valid;
  logic        req_word;
  logic [7:0]  word_address;
  logic [3:0]  current_block;
  logic        busy;
  logic [31:0] w_out;
  logic        w_valid;
  logic [5:0]  w_round;
  logic        w_ready;
  logic        block_done;
  logic        all_done;

  modport master (
    input  msg_ready, num_blocks, word_data, word_valid, w_ready,
    output req_word, word_address, current_block, busy,
           w_out, w_valid, w_round, block_done, all_done
  );

  modport slave (
    output msg_ready, num_blocks, word_data, word_valid, w_ready,
    input  req_word, word_address, current_block, busy,
           w_out, w_valid, w_round, block_done, all_done
  );
endinterface

// File: rtl/msg_window.sv
// 16-word sliding window of the message schedule with the next-W adder tree.
// win[0] holds W[t-1], win[15] holds W[t-16].
module msg_window
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift_en,
  input  logic [31:0] shift_data,
  output logic [31:0] w_next
);

  logic [31:0] win [WORDS_PER_BLOCK];
  logic [31:0] tap_t2, tap_t7, tap_t15, tap_t16;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) win[i] <= '0;
    end else if (shift_en) begin
      win[0] <= shift_data;
      for (int i = 1; i < WORDS_PER_BLOCK; i++) win[i] <= win[i-1];
    end
  end

  assign tap_t2  = win[1];
  assign tap_t7  = win[6];
  assign tap_t15 = win[14];
  assign tap_t16 = win[15];

  assign w_next = sig1(tap_t2) + tap_t7 + sig0(tap_t15) + tap_t16;

endmodule

// File: rtl/msg_schedule_fetch.sv
// Fetches 16 message words per block and streams the 64-entry SHA-256 schedule.
//   state       | meaning
//   S_IDLE      | waiting for msg_ready, block counter cleared
//   S_FETCH     | requesting words 0..15 and passing them through as W0..W15
//   S_EXPAND    | computing W16..W63 from the window, one per advance
//   S_BLOCK_END | W63 accepted; pulse block_done (and all_done on last block)
//   S_WAIT      | busy low one cycle so the controller can re-provide
module msg_schedule_fetch
  import sha256_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  msg_schedule_fetch_if.master  bus
);

  sched_state_t state, state_nxt;

  logic [3:0]  word_idx;
  logic [3:0]  current_block;
  logic [31:0] w_out_q;
  logic        w_valid_q;
  logic [5:0]  w_round_q;

  logic        adv, last_out, load_word, exp_step, more_blocks;
  logic        req_word, busy, block_done, all_done;
  logic [31:0] w_next, shift_data;

  assign adv         = !w_valid_q || bus.w_ready;
  assign last_out    = w_valid_q && (w_round_q == 6'(ROUNDS - 1));
  assign more_blocks = current_block < bus.num_blocks;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (bus.msg_ready) state_nxt = S_FETCH;
      S_FETCH:     if (load_word && (word_idx == 4'(WORDS_PER_BLOCK - 1))) state_nxt = S_EXPAND;
      S_EXPAND:    if (adv && last_out) state_nxt = S_BLOCK_END;
      S_BLOCK_END: state_nxt = more_blocks ? S_WAIT : S_IDLE;
      S_WAIT:      if (bus.msg_ready) state_nxt = S_FETCH;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_word   = 1'b0;
    busy       = 1'b0;
    block_done = 1'b0;
    all_done   = 1'b0;
    case (state)
      S_FETCH: begin
        req_word = adv;
        busy     = 1'b1;
      end
      S_EXPAND: busy = 1'b1;
      S_BLOCK_END: begin
        busy       = 1'b1;
        block_done = 1'b1;
        all_done   = !more_blocks;
      end
      default: ;
    endcase
  end

  assign load_word  = req_word && bus.word_valid;
  // Expansion stops once W63 sits in the output register; it then only waits for acceptance.
  assign exp_step   = (state == S_EXPAND) && adv && !last_out;
  assign shift_data = load_word ? bus.word_data : w_next;

  msg_window u_window (
    .clk        (clk),
    .rst_n      (rst_n),
    .shift_en   (load_word || exp_step),
    .shift_data (shift_data),
    .w_next     (w_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_idx      <= '0;
      current_block <= '0;
      w_out_q       <= '0;
      w_valid_q     <= 1'b0;
      w_round_q     <= '0;
    end else begin
      if (load_word) word_idx <= word_idx + 4'd1;
      if (state == S_BLOCK_END) current_block <= more_blocks ? current_block + 4'd1 : 4'd0;

      if (load_word) begin
        w_out_q   <= bus.word_data;
        w_round_q <= {2'b00, word_idx};
        w_valid_q <= 1'b1;
      end else if (exp_step) begin
        w_out_q   <= w_next;
        w_round_q <= w_round_q + 6'd1;
        w_valid_q <= 1'b1;
      end else if (adv) begin
        w_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_word      = req_word;
  assign bus.word_address  = {current_block, word_idx};
  assign bus.current_block = current_block;
  assign bus.busy          = busy;
  assign bus.w_out         = w_out_q;
  assign bus.w_valid       = w_valid_q;
  assign bus.w_round       = w_round_q;
  assign bus.block_done    = block_done;
  assign bus.all_done      = all_done;

endmodule
